mdu_issue_ctrl: RTL
===================

# mdu_issue_ctrl

Issue and writeback controller for the shared multi-cycle multiply/divide unit (MDU) of the 5-stage RISC-V core. It accepts one MUL/DIV from ID, sequences the iterative unit with a latency counter, and tracks the pending destination register so dependent ID instructions stall. It also arbitrates the single register-file write port against the normal MEM/WB stream. Its stall output is OR-ed into the pipeline stall/flush controls next to the hazard detection unit.

## Interface
- MUL_LAT, 4: cycles from `mdu_start` to result valid for multiply
- DIV_LAT, 33: cycles from `mdu_start` to result valid for divide
- STARVE_LIM, 4: DONE-state wait cycles before a bubble is forced
- clk  in  1  core clock, rising edge
- rst  in  1  reset, synchronous, active-high
- issue_valid_ID  in  1  ID holds a MUL/DIV-class instruction
- is_div_ID  in  1  1 = divide/remainder, 0 = multiply
- rd_ID, rs1_ID, rs2_ID  in  5 each  ID register indices
- rs1use_ID, rs2use_ID  in  1 each  ID source actually read
- flush_ID  in  1  ID instruction is being flushed (branch taken)
- RegWrite_MEM  in  1  instruction in MEM will use the write port next cycle
- mdu_start  out  1  one-cycle launch pulse to the MDU
- mdu_is_div  out  1  operation select, valid with `mdu_start`
- stall_ID  out  1  hold PC and IF/ID, bubble into ID/EX
- bubble_req  out  1  force a bubble into EX/MEM to free a write slot
- mdu_wb_en  out  1  MDU owns the write port this cycle
- mdu_wb_rd  out  5  destination for the MDU write
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BUSY, DONE.
- Accept when `issue_valid_ID & ~flush_ID & ~stall_ID & state==IDLE`:
  - latch rd into `pend_rd` and is_div into `mdu_is_div`.
  - set `pend_v` only if rd != 0.
  - load counter with MUL_LAT-1 or DIV_LAT-1.
  - go to BUSY.
- BUSY: counter decrements each cycle. At 0, go to DONE and clear the starvation counter.
- DONE:
  - If `RegWrite_MEM==0`: `mdu_wb_en=1` for exactly this cycle, then IDLE, clear `pend_v`.
  - Otherwise stay in DONE and increment the starvation counter.
  - When the starvation counter reaches STARVE_LIM, assert `bubble_req` until the write occurs.
- `stall_ID` (combinational) = any of:
  - RAW: `pend_v & rs1use_ID & rs1_ID==pend_rd`, or the same for rs2.
  - WAW: `pend_v & issue_valid_ID & rd_ID==pend_rd`.
  - Structural: `issue_valid_ID & state!=IDLE`.
  - Register x0 never matches.
- `stall_ID` is gated off when `flush_ID=1`.
- Counter width is `$clog2(DIV_LAT)`. MUL_LAT and DIV_LAT must be ≥1.

## Timing
- Reset: state IDLE; counters 0; `pend_v=0`; all outputs 0 in the cycle after `rst` is sampled high.
- Reset mid-operation abandons the op. No `mdu_start` and no `mdu_wb_en` follow.
- Accept at edge T:
  - `mdu_start=1` in cycle T+1 only.
  - DONE entered at T+LAT.
  - Earliest `mdu_wb_en` is in cycle T+LAT.
- A dependent instruction in ID is stalled through the `mdu_wb_en` cycle inclusive and reads the register file one cycle later. This is the default, without the forwarding macro.
- A new MUL/DIV may be accepted in the cycle after `mdu_wb_en`.
- `flush_ID` together with `issue_valid_ID`: no accept, no stall.

## Configuration
- `MDU_WB_BYPASS_EN` defined:
  - adds outputs `fwd_mdu_A`, `fwd_mdu_B`, each 1 bit.
  - each is high in the `mdu_wb_en` cycle when the matching source equals `pend_rd` and is used.
  - RAW stall is released in that same cycle, saving one cycle.
- Not defined: no bypass ports. Stall covers the write cycle as above.

## Structure
- Shared core package holds:
  - state encoding typedef `mdu_state_t`
  - default latency constants `MDU_MUL_LAT` and `MDU_DIV_LAT`
  - the 5-bit register index type
- One natural sub-module: `mdu_latency_counter` (load value, decrement, zero flag).
- The FSM, scoreboard compare and write-port arbitration stay in the top.

## Test plan
- MUL issue, rd=5, RegWrite_MEM=0 → `mdu_start` at T+1, `mdu_wb_en=1` with `mdu_wb_rd=5` at T+4, `busy` falls at T+5.
- DIV rd=7, next instruction reads x7 → `stall_ID=1` from T+1 through T+33, released T+34. With `MDU_WB_BYPASS_EN`: released T+33 and `fwd_mdu_A=1` at T+33.
- RegWrite_MEM held 1 after DONE → no write; `bubble_req=1` after 4 wait cycles; `mdu_wb_en` in the first cycle RegWrite_MEM=0.
- Second MUL in ID while BUSY → `stall_ID=1` (structural); accepted the cycle after `mdu_wb_en`.
- MUL rd=0 → `pend_v` stays 0, no RAW stall on x0 reads; `mdu_wb_en` still pulses once.
- `rst` asserted in BUSY, plus `issue_valid_ID` with `flush_ID=1` → state IDLE, no `mdu_wb_en`; flushed op never accepted, `stall_ID=0`.

Source files
------------

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the MDU issue/writeback controller: FSM encoding,
// default latencies, register index type and small compare helpers.
package mdu_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    localparam int MDU_MUL_LAT    = 4;
    localparam int MDU_DIV_LAT    = 33;
    localparam int MDU_STARVE_LIM = 4;

    typedef logic [4:0] reg_idx_t;

    // Scoreboard compare; x0 is hardwired zero and never creates a dependency.
    function automatic logic reg_hit(input reg_idx_t a, input reg_idx_t b);
        return (a == b) && (a != 5'd0);
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mdu_latency_counter.sv
// Down-counter sequencing the iterative MDU: load, decrement, zero and
// "reaches zero on this decrement" flags.
module mdu_latency_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_last
);

    logic [WIDTH-1:0] r_count;

    // Count register; load has priority over decrement, never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && !o_zero) begin
            r_count <= r_count - WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {WIDTH{1'b0}});
    assign o_last = (r_count == WIDTH'(1));

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU issue, pending-rd scoreboard and register-file write-port arbitration.
// Optional feature: define MDU_WB_BYPASS_EN for writeback-cycle forwarding.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT    = MDU_MUL_LAT,
    parameter int DIV_LAT    = MDU_DIV_LAT,
    parameter int STARVE_LIM = MDU_STARVE_LIM
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     issue_valid_ID,
    input  logic     is_div_ID,
    input  reg_idx_t rd_ID,
    input  reg_idx_t rs1_ID,
    input  reg_idx_t rs2_ID,
    input  logic     rs1use_ID,
    input  logic     rs2use_ID,
    input  logic     flush_ID,
    input  logic     RegWrite_MEM,
    output logic     mdu_start,
    output logic     mdu_is_div,
    output logic     stall_ID,
    output logic     bubble_req,
    output logic     mdu_wb_en,
    output reg_idx_t mdu_wb_rd,
`ifdef MDU_WB_BYPASS_EN
    output logic     fwd_mdu_A,
    output logic     fwd_mdu_B,
`endif
    output logic     busy
);

    localparam int CW = cnt_width(DIV_LAT);
    localparam int SW = cnt_width(STARVE_LIM + 1);
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT - 1);

    mdu_state_t      r_state;
    mdu_state_t      w_state_nxt;
    logic            r_pend_v;
    reg_idx_t        r_pend_rd;
    logic            r_is_div;
    logic            r_start;
    logic [SW-1:0]   r_starve;

    logic            w_accept;
    logic [CW-1:0]   w_ld_val;
    logic            w_ld_zero;
    logic            w_cnt_zero;
    logic            w_cnt_last;
    logic            w_wb_en;
    logic            w_starved;
    logic            w_raw_a;
    logic            w_raw_b;
    logic            w_raw_stall;
    logic            w_waw;
    logic            w_struct;
    logic            w_stall;

    assign w_ld_val  = is_div_ID ? DIV_LD : MUL_LD;
    assign w_ld_zero = (w_ld_val == {CW{1'b0}});

    assign w_raw_a  = r_pend_v & rs1use_ID & reg_hit(rs1_ID, r_pend_rd);
    assign w_raw_b  = r_pend_v & rs2use_ID & reg_hit(rs2_ID, r_pend_rd);
    assign w_waw    = r_pend_v & issue_valid_ID & reg_hit(rd_ID, r_pend_rd);
    assign w_struct = issue_valid_ID & (r_state != ST_IDLE);
    assign w_wb_en  = (r_state == ST_DONE) & ~RegWrite_MEM;
    assign w_starved = (r_state == ST_DONE) & (r_starve == SW'(STARVE_LIM));

`ifdef MDU_WB_BYPASS_EN
    // The writeback value is forwarded directly, so RAW need not wait past it.
    assign w_raw_stall = (w_raw_a | w_raw_b) & ~w_wb_en;
    assign fwd_mdu_A   = w_wb_en & w_raw_a;
    assign fwd_mdu_B   = w_wb_en & w_raw_b;
`else
    assign w_raw_stall = w_raw_a | w_raw_b;
`endif

    assign w_stall  = ~flush_ID & (w_raw_stall | w_waw | w_struct);
    assign w_accept = issue_valid_ID & ~flush_ID & ~w_stall & (r_state == ST_IDLE);

    mdu_latency_counter #(
        .WIDTH (CW)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (w_ld_val),
        .i_dec      (r_state == ST_BUSY),
        .o_zero     (w_cnt_zero),
        .o_last     (w_cnt_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a single-cycle latency skips BUSY entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_ld_zero ? ST_DONE : ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_cnt_last || w_cnt_zero) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (!RegWrite_MEM) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pending-destination scoreboard, launch pulse and operation select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_v  <= 1'b0;
            r_pend_rd <= 5'd0;
            r_is_div  <= 1'b0;
            r_start   <= 1'b0;
        end else begin
            r_start <= w_accept;
            if (w_accept) begin
                r_pend_v  <= (rd_ID != 5'd0);
                r_pend_rd <= rd_ID;
                r_is_div  <= is_div_ID;
            end else if (w_wb_en) begin
                r_pend_v  <= 1'b0;
            end else begin
                r_pend_v  <= r_pend_v;
            end
        end
    end

    // Starvation counter: counts DONE cycles lost to the MEM/WB stream, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= {SW{1'b0}};
        end else if (r_state != ST_DONE) begin
            r_starve <= {SW{1'b0}};
        end else if (RegWrite_MEM && (r_starve != SW'(STARVE_LIM))) begin
            r_starve <= r_starve + SW'(1);
        end else begin
            r_starve <= r_starve;
        end
    end

    // Output decode.
    always_comb begin
        mdu_start  = r_start;
        mdu_is_div = r_is_div;
        stall_ID   = w_stall;
        bubble_req = w_starved;
        mdu_wb_en  = w_wb_en;
        mdu_wb_rd  = r_pend_rd;
        busy       = (r_state != ST_IDLE);
    end

endmodule
